// File: rtl/dpa_pkg.sv
// Shared types and constants for the frame-buffer scan-out stage.
package dpa_pkg;

    localparam int DPA_ADDR_W    = 20;
    localparam int DPA_PIX_W     = 24;
    localparam int DPA_H_ACT_DEF = 256;
    localparam int DPA_V_ACT_DEF = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } scan_state_e;

    // Colour bar: each bit of the bar number drives one full-scale channel.
    function automatic logic [DPA_PIX_W-1:0] bar_pixel(input logic [2:0] b);
        return {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    endfunction

endpackage

// File: rtl/dpa_scan_if.sv
// Pixel stream (ready/valid with frame/line markers) between scan-out and its sink.
interface dpa_scan_if;
    import dpa_pkg::*;

    logic                 pix_valid;
    logic                 pix_ready;
    logic [DPA_PIX_W-1:0] pix_data;
    logic                 pix_sof;
    logic                 pix_eol;
    logic                 pix_eof;

    modport master (output pix_valid, pix_data, pix_sof, pix_eol, pix_eof, input pix_ready);
    modport slave  (input pix_valid, pix_data, pix_sof, pix_eol, pix_eof, output pix_ready);
endinterface

// File: rtl/dpa_scan_fifo.sv
// First-word-fall-through prefetch FIFO with occupancy count and synchronous flush.
module dpa_scan_fifo
    import dpa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DPA_PIX_W-1:0]       push_data,
    input  logic                       pop,
    output logic [DPA_PIX_W-1:0]       head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [DPA_PIX_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = cnt_q;
endmodule

// File: rtl/dpa_scan.sv
// Frame-buffer scan-out: sequential memory reads into a prefetch FIFO, emitted as a marked pixel stream.
// Optional DPA_SCAN_TESTPAT_EN adds a test_pat input that synthesises colour bars instead of reading memory.
module dpa_scan
    import dpa_pkg::*;
#(
    parameter int H_ACT      = DPA_H_ACT_DEF,
    parameter int V_ACT      = DPA_V_ACT_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DPA_ADDR_W-1:0] fb_base,
`ifdef DPA_SCAN_TESTPAT_EN
    input  logic                  test_pat,
`endif
    output logic [DPA_ADDR_W-1:0] FB_A,
    output logic                  FB_REN,
    input  logic [DPA_PIX_W-1:0]  FB_Q,
    dpa_scan_if.master            pix,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int N     = H_ACT * V_ACT;
    localparam int LOG_H = $clog2(H_ACT);
    localparam int OUT_W = $clog2(N) > 0 ? $clog2(N) : 1;
    localparam int IDX_W = OUT_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CW    = CNT_W + 1;

    scan_state_e            state_q, state_d;
    logic [DPA_ADDR_W-1:0]  base_q, base_d;
    logic [IDX_W-1:0]       rd_idx_q, rd_idx_d;
    logic [OUT_W-1:0]       out_idx_q, out_idx_d;
    logic                   inflight_q, inflight_d;
    logic                   issue, pop, pix_valid;
    logic [CNT_W-1:0]       fifo_cnt;
    logic [DPA_PIX_W-1:0]   fifo_head, push_data;
    logic [CW-1:0]          credit_used, credit_lim;

`ifdef DPA_SCAN_TESTPAT_EN
    logic                   tp_q, tp_d;
    logic [DPA_PIX_W-1:0]   pat_q, pat_d;
`endif

    assign pix_valid = (fifo_cnt != '0);
    assign pop       = pix_valid & pix.pix_ready;

    // The pending read counts against FIFO space so backpressure can never overflow it.
    assign credit_used = CW'(fifo_cnt) + CW'(inflight_q);
    assign credit_lim  = CW'(FIFO_DEPTH) + CW'(pop);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        rd_idx_d   = rd_idx_q;
        out_idx_d  = out_idx_q;
        issue      = 1'b0;
        frame_done = 1'b0;
`ifdef DPA_SCAN_TESTPAT_EN
        tp_d  = tp_q;
        pat_d = pat_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d    = fb_base;
                    rd_idx_d  = '0;
                    out_idx_d = '0;
                    state_d   = RUN;
`ifdef DPA_SCAN_TESTPAT_EN
                    tp_d = test_pat;
`endif
                end
            end
            RUN: begin
                if (rd_idx_q < IDX_W'(N) && credit_used < credit_lim) begin
                    issue    = 1'b1;
                    rd_idx_d = rd_idx_q + IDX_W'(1);
`ifdef DPA_SCAN_TESTPAT_EN
                    pat_d = bar_pixel(rd_idx_q[LOG_H-1 -: 3]);
`endif
                    if (rd_idx_q == IDX_W'(N - 1)) state_d = DRAIN;
                end
            end
            DRAIN: ;
            default: state_d = IDLE;
        endcase

        if (pop) begin
            out_idx_d = out_idx_q + OUT_W'(1);
            if (state_q == DRAIN && out_idx_q == OUT_W'(N - 1)) begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
        end

        if (abort) begin
            state_d    = IDLE;
            issue      = 1'b0;
            frame_done = 1'b0;
            rd_idx_d   = rd_idx_q;
        end
        inflight_d = issue;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            rd_idx_q   <= '0;
            out_idx_q  <= '0;
            inflight_q <= 1'b0;
`ifdef DPA_SCAN_TESTPAT_EN
            tp_q  <= 1'b0;
            pat_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            rd_idx_q   <= rd_idx_d;
            out_idx_q  <= out_idx_d;
            inflight_q <= inflight_d;
`ifdef DPA_SCAN_TESTPAT_EN
            tp_q  <= tp_d;
            pat_q <= pat_d;
`endif
        end
    end

`ifdef DPA_SCAN_TESTPAT_EN
    assign FB_REN    = issue & ~tp_q;
    assign push_data = tp_q ? pat_q : FB_Q;
`else
    assign FB_REN    = issue;
    assign push_data = FB_Q;
`endif
    assign FB_A = base_q + DPA_ADDR_W'(rd_idx_q);
    assign busy = (state_q != IDLE);

    dpa_scan_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort),
        .push      (inflight_q),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_cnt)
    );

    assign pix.pix_valid = pix_valid;
    assign pix.pix_data  = pix_valid ? fifo_head : '0;
    assign pix.pix_sof   = pix_valid && (out_idx_q == '0);
    assign pix.pix_eol   = pix_valid && (out_idx_q[LOG_H-1:0] == {LOG_H{1'b1}});
    assign pix.pix_eof   = pix_valid && (out_idx_q == OUT_W'(N - 1));
endmodule
